// File: rtl/bbox_update_ctrl.sv
// rtl/bbox_update_ctrl.sv - bounding-box staging, clamp and frame-synchronous commit controller
//
// Purpose:
//   Accepts detector bounding boxes over a valid/ready handshake, clamps them
//   to the frame, drops degenerate boxes, and stages the newest good box.
//   The staged box is committed to the output registers (with its centre)
//   only on entry to vertical blanking. A hold-off counter invalidates the
//   box after HOLD_FRAMES blanking periods without a fresh commit.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   det_valid/det_ready     detector result handshake
//   det_x_min..det_y_max    detected box edges (9 bit)
//   vblank                  vertical blanking level from timing generator
//   overlap_en              user superimpose enable
//   x_min..y_max            committed box edges
//   x_cen, y_cen            committed box centre
//   disable_overlap         1 = colouriser passes camera only
//   drop_cnt                saturating count of rejected boxes

module bbox_update_ctrl #(
  parameter int X_LIM       = 319,
  parameter int Y_LIM       = 239,
  parameter int HOLD_FRAMES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       det_valid,
  output logic       det_ready,
  input  logic [8:0] det_x_min,
  input  logic [8:0] det_x_max,
  input  logic [8:0] det_y_min,
  input  logic [8:0] det_y_max,
  input  logic       vblank,
  input  logic       overlap_en,
  output logic [8:0] x_min,
  output logic [8:0] x_max,
  output logic [8:0] y_min,
  output logic [8:0] y_max,
  output logic [8:0] x_cen,
  output logic [8:0] y_cen,
  output logic       disable_overlap,
  output logic [7:0] drop_cnt
);

  localparam logic [8:0]     X_LIM_C = 9'(X_LIM);
  localparam logic [8:0]     Y_LIM_C = 9'(Y_LIM);
  localparam logic [CNT_W:0] HOLD_C  = (CNT_W+1)'(HOLD_FRAMES);
  localparam logic [CNT_W:0] ONE_C   = (CNT_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CALC    = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             vblank_q, vblank_d;
  logic [8:0]       stg_x_min_q, stg_x_min_d;
  logic [8:0]       stg_x_max_q, stg_x_max_d;
  logic [8:0]       stg_y_min_q, stg_y_min_d;
  logic [8:0]       stg_y_max_q, stg_y_max_d;
  logic [8:0]       cen_x_q, cen_x_d;
  logic [8:0]       cen_y_q, cen_y_d;
  logic [8:0]       x_min_q, x_min_d;
  logic [8:0]       x_max_q, x_max_d;
  logic [8:0]       y_min_q, y_min_d;
  logic [8:0]       y_max_q, y_max_d;
  logic [8:0]       x_cen_q, x_cen_d;
  logic [8:0]       y_cen_q, y_cen_d;
  logic             box_valid_q, box_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             disable_q, disable_d;

  logic             vb_rise;
  logic             xfer;
  logic             reject;
  logic [8:0]       cx_min, cx_max, cy_min, cy_max;
  logic [9:0]       sum_x, sum_y;
  logic [CNT_W:0]   cnt_inc;

  always_comb begin
    vb_rise   = vblank & ~vblank_q;
    // Blocking acceptance on the blanking edge keeps a late result from
    // slipping into the stage while the commit sequence is launched.
    det_ready = ((state_q == IDLE) || (state_q == PENDING)) & ~vb_rise;
    xfer      = det_valid & det_ready;

    cx_min = (det_x_min > X_LIM_C) ? X_LIM_C : det_x_min;
    cx_max = (det_x_max > X_LIM_C) ? X_LIM_C : det_x_max;
    cy_min = (det_y_min > Y_LIM_C) ? Y_LIM_C : det_y_min;
    cy_max = (det_y_max > Y_LIM_C) ? Y_LIM_C : det_y_max;
    reject = (cx_min >= cx_max) || (cy_min >= cy_max);

    // Centre from a 10-bit sum so 319+319 does not wrap before the shift.
    sum_x   = {1'b0, stg_x_min_q} + {1'b0, stg_x_max_q};
    sum_y   = {1'b0, stg_y_min_q} + {1'b0, stg_y_max_q};
    cnt_inc = {1'b0, cnt_q} + ONE_C;

    state_d     = state_q;
    vblank_d    = vblank;
    stg_x_min_d = stg_x_min_q;
    stg_x_max_d = stg_x_max_q;
    stg_y_min_d = stg_y_min_q;
    stg_y_max_d = stg_y_max_q;
    cen_x_d     = cen_x_q;
    cen_y_d     = cen_y_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    x_cen_d     = x_cen_q;
    y_cen_d     = y_cen_q;
    box_valid_d = box_valid_q;
    cnt_d       = cnt_q;
    drop_cnt_d  = drop_cnt_q;
    disable_d   = ~overlap_en | ~box_valid_q;

    if (xfer) begin
      if (reject) begin
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else begin
        stg_x_min_d = cx_min;
        stg_x_max_d = cx_max;
        stg_y_min_d = cy_min;
        stg_y_max_d = cy_max;
      end
    end

    case (state_q)
      IDLE: begin
        if (vb_rise) begin
          // A blanking edge with nothing staged ages the current box.
          if (box_valid_q) begin
            if (cnt_inc == HOLD_C) begin
              box_valid_d = 1'b0;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
          end
        end else if (xfer && !reject) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vb_rise) begin
          state_d = CALC;
        end
      end
      CALC: begin
        cen_x_d = sum_x[9:1];
        cen_y_d = sum_y[9:1];
        state_d = COMMIT;
      end
      COMMIT: begin
        x_min_d     = stg_x_min_q;
        x_max_d     = stg_x_max_q;
        y_min_d     = stg_y_min_q;
        y_max_d     = stg_y_max_q;
        x_cen_d     = cen_x_q;
        y_cen_d     = cen_y_q;
        box_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vblank_q    <= 1'b1;
      stg_x_min_q <= '0;
      stg_x_max_q <= '0;
      stg_y_min_q <= '0;
      stg_y_max_q <= '0;
      cen_x_q     <= '0;
      cen_y_q     <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      x_cen_q     <= '0;
      y_cen_q     <= '0;
      box_valid_q <= 1'b0;
      cnt_q       <= '0;
      drop_cnt_q  <= '0;
      disable_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      vblank_q    <= vblank_d;
      stg_x_min_q <= stg_x_min_d;
      stg_x_max_q <= stg_x_max_d;
      stg_y_min_q <= stg_y_min_d;
      stg_y_max_q <= stg_y_max_d;
      cen_x_q     <= cen_x_d;
      cen_y_q     <= cen_y_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      x_cen_q     <= x_cen_d;
      y_cen_q     <= y_cen_d;
      box_valid_q <= box_valid_d;
      cnt_q       <= cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      disable_q   <= disable_d;
    end
  end

  assign x_min           = x_min_q;
  assign x_max           = x_max_q;
  assign y_min           = y_min_q;
  assign y_max           = y_max_q;
  assign x_cen           = x_cen_q;
  assign y_cen           = y_cen_q;
  assign disable_overlap = disable_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_bbox_update_ctrl.sv
// tb/tb_bbox_update_ctrl.sv - directed self-checking bench for bbox_update_ctrl

module tb_bbox_update_ctrl;

  logic       clk;
  logic       reset_n;
  logic       det_valid;
  logic       det_ready;
  logic [8:0] det_x_min, det_x_max, det_y_min, det_y_max;
  logic       vblank;
  logic       overlap_en;
  logic [8:0] x_min, x_max, y_min, y_max, x_cen, y_cen;
  logic       disable_overlap;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  bbox_update_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .det_valid       (det_valid),
    .det_ready       (det_ready),
    .det_x_min       (det_x_min),
    .det_x_max       (det_x_max),
    .det_y_min       (det_y_min),
    .det_y_max       (det_y_max),
    .vblank          (vblank),
    .overlap_en      (overlap_en),
    .x_min           (x_min),
    .x_max           (x_max),
    .y_min           (y_min),
    .y_max           (y_max),
    .x_cen           (x_cen),
    .y_cen           (y_cen),
    .disable_overlap (disable_overlap),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_box(input string tag, input int a, input int b, input int c,
                         input int d, input int e, input int f);
    chk({tag, ".x_min"}, int'(x_min), a);
    chk({tag, ".x_max"}, int'(x_max), b);
    chk({tag, ".y_min"}, int'(y_min), c);
    chk({tag, ".y_max"}, int'(y_max), d);
    chk({tag, ".x_cen"}, int'(x_cen), e);
    chk({tag, ".y_cen"}, int'(y_cen), f);
  endtask

  task automatic send(input string tag, input int a, input int b, input int c, input int d);
    det_x_min = 9'(a);
    det_x_max = 9'(b);
    det_y_min = 9'(c);
    det_y_max = 9'(d);
    det_valid = 1'b1;
    #1;
    chk({tag, ".ready"}, int'(det_ready), 1);
    tick();
    det_valid = 1'b0;
  endtask

  // One blanking rise followed by the two cycles needed to reach IDLE again.
  task automatic frame();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    det_valid  = 1'b0;
    det_x_min  = '0;
    det_x_max  = '0;
    det_y_min  = '0;
    det_y_max  = '0;
    vblank     = 1'b0;
    overlap_en = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    chk_box("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.disable", int'(disable_overlap), 1);
    chk("rst.drop", int'(drop_cnt), 0);
    chk("rst.ready", int'(det_ready), 1);

    // Basic commit with latency check
    send("b1", 10, 50, 20, 80);
    vblank = 1'b1;
    #1;
    chk("b1.ready_vbrise", int'(det_ready), 0);
    tick();
    vblank = 1'b0;
    chk("b1.ready_calc", int'(det_ready), 0);
    chk("b1.x_min_calc", int'(x_min), 0);
    tick();
    chk("b1.ready_commit", int'(det_ready), 0);
    chk("b1.x_min_commit", int'(x_min), 0);
    tick();
    chk_box("b1", 10, 50, 20, 80, 30, 50);
    chk("b1.disable_lag", int'(disable_overlap), 1);
    tick();
    chk("b1.disable", int'(disable_overlap), 0);

    // Clamping
    send("clamp", 300, 400, 0, 300);
    frame();
    chk_box("clamp", 300, 319, 0, 239, 309, 119);

    // Degenerate rejects
    send("rejx", 60, 60, 5, 9);
    #1;
    chk("rejx.drop", int'(drop_cnt), 1);
    chk("rejx.ready", int'(det_ready), 1);
    send("rejy", 5, 9, 30, 30);
    #1;
    chk("rejy.drop", int'(drop_cnt), 2);
    frame();
    chk_box("rej", 300, 319, 0, 239, 309, 119);

    // Newer result replaces older one while pending
    send("ow1", 10, 50, 20, 80);
    send("ow2", 100, 200, 20, 80);
    frame();
    chk_box("ow", 100, 200, 20, 80, 150, 50);

    // det_valid held through the blanking edge
    send("hold1", 20, 40, 30, 60);
    det_x_min = 9'd50;
    det_x_max = 9'd90;
    det_y_min = 9'd10;
    det_y_max = 9'd30;
    det_valid = 1'b1;
    vblank    = 1'b1;
    #1;
    chk("hv.ready_vbrise", int'(det_ready), 0);
    tick();
    vblank = 1'b0;
    chk("hv.ready_calc", int'(det_ready), 0);
    tick();
    chk("hv.ready_commit", int'(det_ready), 0);
    tick();
    chk("hv.ready_idle", int'(det_ready), 1);
    chk_box("hv1", 20, 40, 30, 60, 30, 45);
    tick();
    det_valid = 1'b0;
    frame();
    chk_box("hv2", 50, 90, 10, 30, 70, 20);
    tick();
    chk("hv.disable", int'(disable_overlap), 0);

    // Hold-off: box dropped after HOLD_FRAMES empty frames
    for (int i = 0; i < 7; i++) frame();
    tick();
    chk("hold7.disable", int'(disable_overlap), 0);
    frame();
    tick();
    chk("hold8.disable", int'(disable_overlap), 1);
    chk("hold8.x_min", int'(x_min), 50);
    chk("hold8.x_cen", int'(x_cen), 70);

    // User enable
    send("en", 10, 50, 20, 80);
    frame();
    tick();
    chk("en.on", int'(disable_overlap), 0);
    overlap_en = 1'b0;
    tick();
    chk("en.off", int'(disable_overlap), 1);
    tick();
    chk("en.off2", int'(disable_overlap), 1);
    overlap_en = 1'b1;
    tick();
    chk("en.back", int'(disable_overlap), 0);

    // drop_cnt saturation
    det_x_min = 9'd60;
    det_x_max = 9'd60;
    det_y_min = 9'd5;
    det_y_max = 9'd9;
    det_valid = 1'b1;
    for (int i = 0; i < 253; i++) tick();
    chk("sat.drop255", int'(drop_cnt), 255);
    for (int i = 0; i < 5; i++) tick();
    chk("sat.hold", int'(drop_cnt), 255);
    chk("sat.ready", int'(det_ready), 1);
    det_valid = 1'b0;

    // Reset in the middle of a pending sequence
    send("mr", 30, 70, 40, 100);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr.x_min_rst", int'(x_min), 0);
    chk("mr.drop_rst", int'(drop_cnt), 0);
    frame();
    chk_box("mr", 0, 0, 0, 0, 0, 0);
    tick();
    chk("mr.disable", int'(disable_overlap), 1);
    chk("mr.ready", int'(det_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
